// File: rtl/hex_segment_decoder.sv
// Recovers a hex digit from an active-low seven-segment bus,
// accepting a pattern only once it has held for STABLE_CYCLES samples.
module hex_segment_decoder #(
  parameter int STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [6:0] segIn,
  output logic [3:0] value,
  output logic       newValue,
  output logic       error,
  output logic       blank
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [6:0]      seg_q;
  logic [6:0]      last;
  logic [6:0]      cand;
  logic [6:0]      cand_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic            emit;
  logic            legal;
  logic [3:0]      digit;

  always_comb begin
    legal = 1'b1;
    digit = 4'h0;
    unique case (cand)
      7'b1000000: digit = 4'h0;
      7'b1111001: digit = 4'h1;
      7'b0100100: digit = 4'h2;
      7'b0110000: digit = 4'h3;
      7'b0011001: digit = 4'h4;
      7'b0010010: digit = 4'h5;
      7'b0000010: digit = 4'h6;
      7'b1111000: digit = 4'h7;
      7'b0000000: digit = 4'h8;
      7'b0010000: digit = 4'h9;
      7'b0001000: digit = 4'hA;
      7'b0000011: digit = 4'hB;
      7'b1000110: digit = 4'hC;
      7'b0100001: digit = 4'hD;
      7'b0000110: digit = 4'hE;
      7'b0001110: digit = 4'hF;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand;
    cnt_d   = cnt;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seg_q != last) begin
          state_d = SETTLE;
          cand_d  = seg_q;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (seg_q != cand) begin
          cand_d = seg_q;
          cnt_d  = CW'(1);
        end else if (cand == last) begin
          // bus bounced back to the pattern already reported
          state_d = IDLE;
        end else if (cnt == LAST_CNT) begin
          emit    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      seg_q    <= SEG_ZERO;
      last     <= SEG_ZERO;
      cand     <= SEG_ZERO;
      cnt      <= '0;
      state_q  <= IDLE;
      value    <= 4'h0;
      newValue <= 1'b0;
      error    <= 1'b0;
      blank    <= 1'b0;
    end else begin
      seg_q    <= segIn;
      state_q  <= state_d;
      cand     <= cand_d;
      cnt      <= cnt_d;
      newValue <= emit;
      if (emit) begin
        last <= cand;
        if (legal) begin
          value <= digit;
          error <= 1'b0;
          blank <= 1'b0;
        end else if (cand == SEG_BLANK) begin
          blank <= 1'b1;
          error <= 1'b0;
        end else begin
          error <= 1'b1;
          blank <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Scoreboard bench for hex_segment_decoder: stimulus queues expected
// strobes, a negedge monitor pops and checks them.
module tb_hex_segment_decoder;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] segIn = 7'b1000000;
  logic [3:0] value;
  logic       newValue;
  logic       error;
  logic       blank;

  hex_segment_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk),
    .Reset(Reset),
    .segIn(segIn),
    .value(value),
    .newValue(newValue),
    .error(error),
    .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] v;
    logic       e;
    logic       b;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [6:0] pats [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (newValue) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d value=%h error=%b blank=%b",
                 cyc, value, error, blank);
      end else begin
        ex = sb.pop_front();
        if (value !== ex.v || error !== ex.e || blank !== ex.b
            || cyc != ex.cyc) begin
          bad++;
          $display("FAIL strobe got v=%h e=%b b=%b cyc=%0d want v=%h e=%b b=%b cyc=%0d",
                   value, error, blank, cyc, ex.v, ex.e, ex.b, ex.cyc);
        end
      end
    end
  end

  task automatic push(input logic [3:0] v, input logic e, input logic b);
    exp_t t;
    t.v = v;
    t.e = e;
    t.b = b;
    t.cyc = cyc + S + 1;
    sb.push_back(t);
  endtask

  task automatic drive(input logic [6:0] p, input int n);
    segIn = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_value", value, 0);
    check("rst_newvalue", newValue, 0);
    Reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_value", value, 0);
    check("idle_error", error, 0);
    check("idle_blank", blank, 0);

    push(4'h3, 1'b0, 1'b0);
    drive(7'b0110000, 6);
    check("hold3_value", value, 3);

    drive(7'b0011001, 2);
    push(4'h5, 1'b0, 1'b0);
    drive(7'b0010010, 6);

    for (int i = 0; i < 16; i++) begin
      push(4'(i), 1'b0, 1'b0);
      drive(pats[i], 5);
    end
    check("sweep_error", error, 0);

    push(4'hF, 1'b0, 1'b1);
    drive(7'b1111111, 6);
    check("blank_flag", blank, 1);

    push(4'hF, 1'b1, 1'b0);
    drive(7'b0101010, 6);
    check("illegal_error", error, 1);
    check("illegal_value", value, 15);

    push(4'h1, 1'b0, 1'b0);
    drive(7'b1111001, 6);
    drive(7'b0100100, 1);
    drive(7'b1111001, 6);
    check("glitch_value", value, 1);

    drive(7'b0000000, 2);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_value", value, 0);
    check("midrst_error", error, 0);
    check("midrst_blank", blank, 0);
    check("midrst_newvalue", newValue, 0);
    push(4'h8, 1'b0, 1'b0);
    Reset = 1'b0;
    repeat (6) @(negedge clk);
    check("release_value", value, 8);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_segment_decoder.md
Name: hex_segment_decoder

Overview:
- Receive side of the seven-segment display bus: watches an active-low 7-bit segment pattern and recovers the 4-bit hex digit it represents.
- A pattern is accepted only after it has held steady for STABLE_CYCLES consecutive samples. This filters glitches and transitions, and each accepted change produces a one-cycle strobe.
- Used for loopback checking of the hex display path and for reading segment buses from external boards back into the design.

Parameters:
- STABLE_CYCLES, 3, consecutive identical samples required before a pattern is accepted. Legal range is 2..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- segIn  input  7  segment bus, active-low, bit 6 = g … bit 0 = a.
- value  output  4  last successfully decoded digit.
- newValue  output  1  one-cycle pulse when an accepted pattern updates the outputs.
- error  output  1  last accepted pattern was not a legal digit or blank.
- blank  output  1  last accepted pattern was all segments off (7'b1111111).

Behaviour:
- All outputs are registered. Reset values: value = 0, newValue = 0, error = 0, blank = 0.
- On Reset, the internal state also resets: seg_q = 7'b1000000, last = 7'b1000000, cand = 7'b1000000, cnt = 0, state = IDLE.
- Input register: seg_q <= segIn every cycle, and on Reset takes its reset value above. seg_q is the only input to the logic below.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank = 1111111
  - Any other pattern is illegal.
- FSM states: IDLE, SETTLE.
- IDLE:
  - If seg_q != last: go to SETTLE, cand <= seg_q, cnt <= 1.
  - Otherwise stay in IDLE.
- SETTLE:
  - If seg_q != cand: cand <= seg_q, cnt <= 1, stay in SETTLE (restart the qualification).
  - Else, if cand == last: go to IDLE with no strobe (the bus bounced back to the old pattern).
  - Else, if cnt == STABLE_CYCLES-1: emit, then go to IDLE.
  - Otherwise cnt <= cnt+1.
- Emit, all in the same edge:
  - last <= cand and newValue <= 1.
  - Legal digit: value <= digit, error <= 0, blank <= 0.
  - Blank pattern: blank <= 1, error <= 0, value unchanged.
  - Illegal pattern: error <= 1, blank <= 0, value unchanged.
- newValue is 0 in every cycle that is not an emit.
- Latency: if segIn first holds pattern P at edge t0 and stays at P, the outputs and newValue update at edge t0+STABLE_CYCLES.
- Timing edge cases:
  - A change that holds for fewer than STABLE_CYCLES samples produces no strobe.
  - Back-to-back distinct stable patterns each produce exactly one strobe.
- cnt is $clog2(STABLE_CYCLES+1) bits wide and never exceeds STABLE_CYCLES-1.
- Reset asserted mid-SETTLE: next edge returns to IDLE with reset values and no strobe. Reset has priority over all other events in the same cycle.
- After reset, a bus displaying "0" (1000000) produces no strobe, because last already equals that pattern.

Test Plan:
- Reset with segIn = 1000000 held for 10 cycles -> value = 0, newValue never asserted, error = 0, blank = 0.
- segIn = 0110000 from edge t0, held -> newValue = 1 for exactly one cycle after edge t0+3, value = 3; no further pulses while held.
- segIn = 0011001 for 2 samples, then 0010010 held -> no strobe for "4"; a single strobe with value = 5 at 3 edges after 0010010 is first sampled.
- Sweep all 16 legal patterns, each held 5 cycles -> 16 strobes with value 0..F in order, error = 0 throughout; then 1111111 -> strobe, blank = 1, value = F.
- segIn = 0101010 (illegal) held -> strobe, error = 1, value unchanged. Glitch from 1111001 to 0100100 for 1 cycle and back -> no strobe.
- Reset asserted during SETTLE of 0000000 -> no strobe, outputs at reset values. Releasing Reset with 0000000 still held -> strobe, value = 8, STABLE_CYCLES+1 edges after Reset deasserts.
